// File: rtl/rvc_compressor_if.sv
// Stream interface of the RVC compressor: instruction input, flush control,
// packed-word output and the compressed-instruction counter.
interface rvc_compressor_if #(
  parameter int unsigned CNT_W = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      in_inst_i;
  logic             flush_i;
  logic             flush_done_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [31:0]      out_word_o;
  logic [CNT_W-1:0] comp_cnt_o;

  modport slave (
    input  in_valid_i, in_inst_i, flush_i, out_ready_i,
    output in_ready_o, flush_done_o, out_valid_o, out_word_o, comp_cnt_o
  );

  modport master (
    output in_valid_i, in_inst_i, flush_i, out_ready_i,
    input  in_ready_o, flush_done_o, out_valid_o, out_word_o, comp_cnt_o
  );
endinterface

// File: rtl/rvc_compressor.sv
// Streaming RV64 instruction compressor: re-encodes a subset of RV32/64
// instructions as RVC parcels and packs the parcel stream into 32-bit words.
module rvc_compressor #(
  parameter bit          ENABLE_COMPRESS = 1'b1,
  parameter logic [15:0] NOP_HW          = 16'h0001,
  parameter int unsigned CNT_W           = 32
) (
  input logic             clk,
  input logic             rst,
  rvc_compressor_if.slave bus
);

  typedef enum logic [6:0] {
    OP_LOAD  = 7'b0000011,
    OP_IMM   = 7'b0010011,
    OP_STORE = 7'b0100011,
    OP_REG   = 7'b0110011
  } opcode_e;

  logic [31:0] inst;
  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] imm_i;
  logic [11:0] imm_s;

  assign inst  = bus.in_inst_i;
  assign opc   = inst[6:0];
  assign rd    = inst[11:7];
  assign f3    = inst[14:12];
  assign rs1   = inst[19:15];
  assign rs2   = inst[24:20];
  assign f7    = inst[31:25];
  assign imm_i = inst[31:20];
  assign imm_s = {inst[31:25], inst[11:7]};

  logic is_addi, is_add, is_lw, is_ld, is_sw, is_sd;
  logic imm6_ok, rd_p, rs1_p, rs2_p;
  logic lwsp_ok, lw_ok, ld_ok, swsp_ok, sw_ok, sd_ok;

  assign is_addi = (opc == OP_IMM)   && (f3 == 3'b000);
  assign is_add  = (opc == OP_REG)   && (f3 == 3'b000) && (f7 == 7'd0);
  assign is_lw   = (opc == OP_LOAD)  && (f3 == 3'b010);
  assign is_ld   = (opc == OP_LOAD)  && (f3 == 3'b011);
  assign is_sw   = (opc == OP_STORE) && (f3 == 3'b010);
  assign is_sd   = (opc == OP_STORE) && (f3 == 3'b011);

  // A 12-bit immediate fits in 6 signed bits when bits 11:5 are all equal.
  assign imm6_ok = (imm_i[11:5] == '0) || (imm_i[11:5] == '1);

  assign rd_p  = (rd[4:3]  == 2'b01);
  assign rs1_p = (rs1[4:3] == 2'b01);
  assign rs2_p = (rs2[4:3] == 2'b01);

  assign lwsp_ok = (imm_i[11:8] == '0) && (imm_i[1:0] == '0);
  assign lw_ok   = (imm_i[11:7] == '0) && (imm_i[1:0] == '0);
  assign ld_ok   = (imm_i[11:8] == '0) && (imm_i[2:0] == '0);
  assign swsp_ok = (imm_s[11:8] == '0) && (imm_s[1:0] == '0);
  assign sw_ok   = (imm_s[11:7] == '0) && (imm_s[1:0] == '0);
  assign sd_ok   = (imm_s[11:8] == '0) && (imm_s[2:0] == '0);

  logic        c_ok;
  logic [15:0] c_hw;

  always_comb begin
    c_ok = 1'b0;
    c_hw = '0;
    if (is_addi && rd == 5'd0 && rs1 == 5'd0 && imm_i == '0) begin
      c_ok = 1'b1;
      c_hw = 16'h0001;
    end else if (is_addi && rs1 == 5'd0 && rd != 5'd0 && imm6_ok) begin
      c_ok = 1'b1;
      c_hw = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
    end else if (is_addi && rs1 == rd && rd != 5'd0 && imm_i != '0 && imm6_ok) begin
      c_ok = 1'b1;
      c_hw = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
    end else if (is_add && rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0) begin
      c_ok = 1'b1;
      c_hw = {4'b1000, rd, rs2, 2'b10};
    end else if (is_add && rs1 == rd && rd != 5'd0 && rs2 != 5'd0) begin
      c_ok = 1'b1;
      c_hw = {4'b1001, rd, rs2, 2'b10};
    end else if (is_lw && rs1 == 5'd2 && rd != 5'd0 && lwsp_ok) begin
      c_ok = 1'b1;
      c_hw = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
    end else if (is_sw && rs1 == 5'd2 && swsp_ok) begin
      c_ok = 1'b1;
      c_hw = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
    end else if (is_lw && rs1_p && rd_p && lw_ok) begin
      c_ok = 1'b1;
      c_hw = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
    end else if (is_sw && rs1_p && rs2_p && sw_ok) begin
      c_ok = 1'b1;
      c_hw = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
    end else if (is_ld && rs1_p && rd_p && ld_ok) begin
      c_ok = 1'b1;
      c_hw = {3'b011, imm_i[5:3], rs1[2:0], imm_i[7:6], rd[2:0], 2'b00};
    end else if (is_sd && rs1_p && rs2_p && sd_ok) begin
      c_ok = 1'b1;
      c_hw = {3'b111, imm_s[5:3], rs1[2:0], imm_s[7:6], rs2[2:0], 2'b00};
    end
    if (!ENABLE_COMPRESS) begin
      c_ok = 1'b0;
      c_hw = '0;
    end
  end

  logic             pend_v_q, pend_v_d;
  logic [15:0]      pend_hw_q, pend_hw_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_word_q, out_word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        out_free, in_ready, accept, flush_emit, emit;
  logic [31:0] emit_word;

  assign out_free   = !out_valid_q || bus.out_ready_i;
  assign in_ready   = !bus.flush_i && out_free;
  assign accept     = bus.in_valid_i && in_ready;
  assign flush_emit = bus.flush_i && pend_v_q && out_free;

  always_comb begin
    pend_v_d  = pend_v_q;
    pend_hw_d = pend_hw_q;
    emit      = 1'b0;
    emit_word = '0;
    if (flush_emit) begin
      emit      = 1'b1;
      emit_word = {NOP_HW, pend_hw_q};
      pend_v_d  = 1'b0;
    end else if (accept) begin
      if (!pend_v_q) begin
        if (c_ok) begin
          pend_hw_d = c_hw;
          pend_v_d  = 1'b1;
        end else begin
          emit      = 1'b1;
          emit_word = inst;
        end
      end else if (c_ok) begin
        emit      = 1'b1;
        emit_word = {c_hw, pend_hw_q};
        pend_v_d  = 1'b0;
      end else begin
        // Low half completes the current word; high half becomes the new pending half.
        emit      = 1'b1;
        emit_word = {inst[15:0], pend_hw_q};
        pend_hw_d = inst[31:16];
      end
    end
    out_valid_d = emit ? 1'b1 : (bus.out_ready_i ? 1'b0 : out_valid_q);
    out_word_d  = emit ? emit_word : out_word_q;
    cnt_d       = (accept && c_ok) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v_q    <= 1'b0;
      pend_hw_q   <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      cnt_q       <= '0;
    end else begin
      pend_v_q    <= pend_v_d;
      pend_hw_q   <= pend_hw_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready_o   = in_ready;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_word_o   = out_word_q;
  assign bus.comp_cnt_o   = cnt_q;
  // Done already in the cycle the last word is being taken by the consumer.
  assign bus.flush_done_o = !pend_v_q && (!out_valid_q || bus.out_ready_i);

endmodule

// File: tb/tb_rvc_compressor.sv
// Self-checking bench for rvc_compressor: directed scenarios plus a random
// stream checked by unpacking and expanding the parcels with a reference decoder.
module tb_rvc_compressor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rvc_compressor_if #(.CNT_W(32)) bus    ();
  rvc_compressor_if #(.CNT_W(32)) bus_pt ();
  rvc_compressor_if #(.CNT_W(3))  bus_w  ();

  rvc_compressor #(.ENABLE_COMPRESS(1'b1), .NOP_HW(16'h0001), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  rvc_compressor #(.ENABLE_COMPRESS(1'b0), .NOP_HW(16'h0001), .CNT_W(32)) dut_pt (
    .clk(clk), .rst(rst), .bus(bus_pt));
  rvc_compressor #(.ENABLE_COMPRESS(1'b1), .NOP_HW(16'h0001), .CNT_W(3)) dut_w (
    .clk(clk), .rst(rst), .bus(bus_w));

  int total = 0;
  int bad   = 0;
  logic [31:0] wq[$];
  logic [15:0] hw_q[$];
  bit accepted, last_done, done_at_hs;

  // ---------------- reference helpers ----------------
  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    return 32'(((imm & 'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op);
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3, int op);
    return 32'((((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
               ((imm & 31) << 7) | op);
  endfunction

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd, int op);
    return 32'((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op);
  endfunction

  function automatic bit is_p(int r);
    return r >= 8 && r <= 15;
  endfunction

  // Whether an instruction is expected to become a 16-bit parcel.
  function automatic bit model_c16(logic [31:0] x);
    int op, f3, rd, rs1, rs2, f7, ii, si;
    op = int'(x[6:0]); f3 = int'(x[14:12]); rd = int'(x[11:7]);
    rs1 = int'(x[19:15]); rs2 = int'(x[24:20]); f7 = int'(x[31:25]);
    ii = int'($signed(x[31:20]));
    si = int'($signed({x[31:25], x[11:7]}));
    if (op == 'h13 && f3 == 0) begin
      if (rd == 0 && rs1 == 0 && ii == 0) return 1;
      if (rs1 == 0 && rd != 0 && ii >= -32 && ii <= 31) return 1;
      if (rs1 == rd && rd != 0 && ii != 0 && ii >= -32 && ii <= 31) return 1;
      return 0;
    end
    if (op == 'h33 && f3 == 0 && f7 == 0)
      return rd != 0 && rs2 != 0 && (rs1 == 0 || rs1 == rd);
    if (op == 'h03 && f3 == 2 && ii >= 0 && ii % 4 == 0)
      return (rs1 == 2 && rd != 0 && ii <= 252) || (is_p(rs1) && is_p(rd) && ii <= 124);
    if (op == 'h03 && f3 == 3 && ii >= 0 && ii % 8 == 0)
      return is_p(rs1) && is_p(rd) && ii <= 248;
    if (op == 'h23 && f3 == 2 && si >= 0 && si % 4 == 0)
      return (rs1 == 2 && si <= 252) || (is_p(rs1) && is_p(rs2) && si <= 124);
    if (op == 'h23 && f3 == 3 && si >= 0 && si % 8 == 0)
      return is_p(rs1) && is_p(rs2) && si <= 248;
    return 0;
  endfunction

  // RVC expander for the supported subset; anything else expands to 0.
  function automatic logic [31:0] expand(logic [15:0] h);
    int q, f3, r, r2, v, off, rp, rsp;
    q = int'(h[1:0]); f3 = int'(h[15:13]); r = int'(h[11:7]); r2 = int'(h[6:2]);
    rp = 8 + int'(h[4:2]); rsp = 8 + int'(h[9:7]);
    v = int'(h[12]) * 32 + int'(h[6:2]);
    if (v >= 32) v = v - 64;
    if (q == 1 && f3 == 0) return enc_i(v, r, 0, r, 'h13);
    if (q == 1 && f3 == 2) return enc_i(v, 0, 0, r, 'h13);
    if (q == 2 && f3 == 4 && h[12] == 1'b0) return enc_r(0, r2, 0, 0, r, 'h33);
    if (q == 2 && f3 == 4 && h[12] == 1'b1) return enc_r(0, r2, r, 0, r, 'h33);
    if (q == 2 && f3 == 2) begin
      off = int'(h[3:2]) * 64 + int'(h[12]) * 32 + int'(h[6:4]) * 4;
      return enc_i(off, 2, 2, r, 'h03);
    end
    if (q == 2 && f3 == 6) begin
      off = int'(h[8:7]) * 64 + int'(h[12:9]) * 4;
      return enc_s(off, r2, 2, 2, 'h23);
    end
    if (q == 0 && (f3 == 2 || f3 == 6)) begin
      off = int'(h[5]) * 64 + int'(h[12:10]) * 8 + int'(h[6]) * 4;
      return (f3 == 2) ? enc_i(off, rsp, 2, rp, 'h03) : enc_s(off, rp, rsp, 2, 'h23);
    end
    if (q == 0 && (f3 == 3 || f3 == 7)) begin
      off = int'(h[6:5]) * 64 + int'(h[12:10]) * 8;
      return (f3 == 3) ? enc_i(off, rsp, 3, rp, 'h03) : enc_s(off, rp, rsp, 3, 'h23);
    end
    return 32'h0;
  endfunction

  function automatic int pick_reg();
    case ($urandom_range(0, 3))
      0:       return 0;
      1, 2:    return 8 + int'($urandom_range(0, 7));
      default: return int'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [31:0] gen_inst();
    int rd, rs1, rs2, imm, base, off;
    rd = pick_reg(); rs2 = pick_reg();
    case ($urandom_range(0, 2))
      0:       rs1 = 0;
      1:       rs1 = rd;
      default: rs1 = pick_reg();
    endcase
    imm = int'($urandom_range(0, 80)) - 40;
    if ($urandom_range(0, 4) == 0) imm = int'($urandom_range(0, 4095)) - 2048;
    case ($urandom_range(0, 2))
      0:       base = 2;
      1:       base = 8 + int'($urandom_range(0, 7));
      default: base = int'($urandom_range(0, 31));
    endcase
    off = int'($urandom_range(0, 70)) * 4 - 8;
    if ($urandom_range(0, 5) == 0) off = off + 2;
    case ($urandom_range(0, 7))
      0: return enc_i(imm, rs1, 0, rd, 'h13);
      1: return enc_r(($urandom_range(0, 5) == 0) ? 'h20 : 0, rs2, rs1, 0, rd, 'h33);
      2: return enc_i(off, base, 2, rd, 'h03);
      3: return enc_i(off, base, 3, rd, 'h03);
      4: return enc_s(off, rs2, base, 2, 'h23);
      5: return enc_s(off, rs2, base, 3, 'h23);
      6: return ($urandom & 32'hffff_f000) | 32'(rd << 7) | 32'h37;
      default: return $urandom | 32'h3;
    endcase
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic cycle();
    @(negedge clk);
    last_done = bus.flush_done_o;
    accepted  = bus.in_valid_i && bus.in_ready_o;
    if (bus.out_valid_o && bus.out_ready_i) begin
      wq.push_back(bus.out_word_o);
      hw_q.push_back(bus.out_word_o[15:0]);
      hw_q.push_back(bus.out_word_o[31:16]);
      done_at_hs = bus.flush_done_o;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid_i = 0;    bus.in_inst_i = '0;    bus.flush_i = 0;    bus.out_ready_i = 1;
    bus_pt.in_valid_i = 0; bus_pt.in_inst_i = '0; bus_pt.flush_i = 0; bus_pt.out_ready_i = 1;
    bus_w.in_valid_i = 0;  bus_w.in_inst_i = '0;  bus_w.flush_i = 0;  bus_w.out_ready_i = 1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    wq.delete(); hw_q.delete();
  endtask

  task automatic send(input logic [31:0] x);
    bus.in_valid_i = 1'b1; bus.in_inst_i = x; accepted = 0;
    for (int n = 0; n < 50 && !accepted; n++) cycle();
    bus.in_valid_i = 1'b0;
    if (!accepted) begin
      total++; bad++;
      $display("FAIL send_timeout: inst %h accepted=0 required=1", x);
    end
  endtask

  task automatic flush_wait();
    bus.flush_i = 1'b1; bus.out_ready_i = 1'b1; last_done = 0;
    for (int n = 0; n < 50 && !last_done; n++) cycle();
    bus.flush_i = 1'b0;
    if (!last_done) begin
      total++; bad++;
      $display("FAIL flush_timeout: flush_done=0 required=1");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total += 5;
    if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.out_valid_o); end
    if (bus.out_word_o !== 32'h0) begin bad++; $display("FAIL rst_word: got %h want 0", bus.out_word_o); end
    if (bus.comp_cnt_o !== 32'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", bus.comp_cnt_o); end
    if (bus.flush_done_o !== 1'b1) begin bad++; $display("FAIL rst_done: got %b want 1", bus.flush_done_o); end
    if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", bus.in_ready_o); end
  endtask

  task automatic test_addi_pair();
    do_reset();
    send(32'h00150513); send(32'h00150513); cycle(); cycle();
    total += 3;
    if (wq.size() != 1) begin bad++; $display("FAIL pair_count: got %0d want 1", wq.size()); end
    if (wq.size() == 0 || wq[0] !== 32'h05050505) begin
      bad++; $display("FAIL pair_word: got %h want 05050505", (wq.size() != 0) ? wq[0] : 32'hx);
    end
    if (bus.comp_cnt_o !== 32'd2) begin bad++; $display("FAIL pair_cnt: got %0d want 2", bus.comp_cnt_o); end
  endtask

  task automatic test_lw_flush();
    do_reset();
    send(32'h0044A403);
    done_at_hs = 0;
    flush_wait();
    total += 2;
    if (wq.size() != 1 || wq[0] !== 32'h000140C0) begin
      bad++; $display("FAIL lw_flush_word: got %h (n=%0d) want 000140C0", (wq.size() != 0) ? wq[0] : 32'hx, wq.size());
    end
    if (done_at_hs !== 1'b1) begin bad++; $display("FAIL lw_flush_done_at_take: got %b want 1", done_at_hs); end
  endtask

  task automatic test_mixed_lui();
    do_reset();
    send(32'h00150513); send(32'h123452B7); cycle();
    flush_wait();
    total += 3;
    if (wq.size() < 1 || wq[0] !== 32'h52B70505) begin
      bad++; $display("FAIL mixed_word0: got %h want 52B70505", (wq.size() > 0) ? wq[0] : 32'hx);
    end
    if (wq.size() < 2 || wq[1] !== 32'h00011234) begin
      bad++; $display("FAIL mixed_word1: got %h want 00011234", (wq.size() > 1) ? wq[1] : 32'hx);
    end
    if (bus.comp_cnt_o !== 32'd1) begin bad++; $display("FAIL mixed_cnt: got %0d want 1", bus.comp_cnt_o); end
  endtask

  task automatic test_passthrough();
    do_reset();
    bus_pt.in_valid_i = 1'b1; bus_pt.in_inst_i = 32'h00150513;
    @(negedge clk);
    total++;
    if (bus_pt.in_ready_o !== 1'b1) begin bad++; $display("FAIL pt_ready: got %b want 1", bus_pt.in_ready_o); end
    @(posedge clk); #1;
    bus_pt.in_valid_i = 1'b0;
    total += 3;
    if (bus_pt.out_valid_o !== 1'b1) begin bad++; $display("FAIL pt_valid: got %b want 1", bus_pt.out_valid_o); end
    if (bus_pt.out_word_o !== 32'h00150513) begin bad++; $display("FAIL pt_word: got %h want 00150513", bus_pt.out_word_o); end
    if (bus_pt.comp_cnt_o !== 32'd0) begin bad++; $display("FAIL pt_cnt: got %0d want 0", bus_pt.comp_cnt_o); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready_i = 1'b0;
    send(32'h123452B7);
    bus.in_valid_i = 1'b1; bus.in_inst_i = 32'h00500093;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      total += 3;
      if (bus.out_valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1", n, bus.out_valid_o); end
      if (bus.in_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 0", n, bus.in_ready_o); end
      if (bus.out_word_o !== 32'h123452B7) begin bad++; $display("FAIL bp_stable[%0d]: got %h want 123452B7", n, bus.out_word_o); end
      @(posedge clk); #1;
    end
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready_o); end
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    total += 2;
    if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL bp_after_valid: got %b want 0", bus.out_valid_o); end
    if (bus.comp_cnt_o !== 32'd1) begin bad++; $display("FAIL bp_after_cnt: got %0d want 1", bus.comp_cnt_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.out_ready_i = 1'b0;
    send(32'h00150513); send(32'h123452B7);
    total += 2;
    if (bus.out_valid_o !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid: got %b want 1", bus.out_valid_o); end
    if (bus.flush_done_o !== 1'b0) begin bad++; $display("FAIL rmid_pre_done: got %b want 0", bus.flush_done_o); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total += 4;
    if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", bus.out_valid_o); end
    if (bus.flush_done_o !== 1'b1) begin bad++; $display("FAIL rmid_done: got %b want 1", bus.flush_done_o); end
    if (bus.comp_cnt_o !== 32'd0) begin bad++; $display("FAIL rmid_cnt: got %0d want 0", bus.comp_cnt_o); end
    if (bus.out_word_o !== 32'h0) begin bad++; $display("FAIL rmid_word: got %h want 0", bus.out_word_o); end
    wq.delete();
    bus.out_ready_i = 1'b1; bus.flush_i = 1'b1;
    repeat (3) cycle();
    bus.flush_i = 1'b0;
    total++;
    if (wq.size() != 0) begin bad++; $display("FAIL rmid_flush_words: got %0d want 0", wq.size()); end
  endtask

  task automatic test_flush_block();
    do_reset();
    bus.in_valid_i = 1'b1; bus.in_inst_i = 32'h00150513; bus.flush_i = 1'b1;
    @(negedge clk);
    total += 2;
    if (bus.in_ready_o !== 1'b0) begin bad++; $display("FAIL fb_ready: got %b want 0", bus.in_ready_o); end
    if (bus.flush_done_o !== 1'b1) begin bad++; $display("FAIL fb_done: got %b want 1", bus.flush_done_o); end
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0; bus.flush_i = 1'b0;
    @(negedge clk);
    total += 2;
    if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL fb_valid: got %b want 0", bus.out_valid_o); end
    if (bus.comp_cnt_o !== 32'd0) begin bad++; $display("FAIL fb_cnt: got %0d want 0", bus.comp_cnt_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    bus_w.in_valid_i = 1'b1; bus_w.in_inst_i = 32'h00150513;
    repeat (9) begin @(posedge clk); #1; end
    bus_w.in_valid_i = 1'b0;
    total++;
    if (bus_w.comp_cnt_o !== 3'd1) begin bad++; $display("FAIL cnt_wrap: got %0d want 1", bus_w.comp_cnt_o); end
  endtask

  task automatic test_random();
    logic [31:0] ins[$];
    int n16, p;
    logic [31:0] got;
    bit got16;
    do_reset();
    ins = '{32'h00000013, 32'h00100013, enc_i(-32, 0, 0, 5, 'h13), enc_i(31, 0, 0, 5, 'h13),
            enc_i(32, 0, 0, 5, 'h13), enc_i(0, 0, 0, 5, 'h13), enc_i(0, 5, 0, 5, 'h13),
            enc_i(-32, 5, 0, 5, 'h13), enc_i(31, 5, 0, 5, 'h13), enc_i(-33, 5, 0, 5, 'h13),
            enc_r(0, 4, 0, 0, 3, 'h33), enc_r(0, 0, 0, 0, 3, 'h33), enc_r(0, 0, 3, 0, 3, 'h33),
            enc_r(0, 7, 3, 0, 3, 'h33), enc_i(252, 2, 2, 1, 'h03), enc_i(256, 2, 2, 1, 'h03),
            enc_i(4, 2, 2, 0, 'h03), enc_s(252, 0, 2, 2, 'h23), enc_i(124, 15, 2, 8, 'h03),
            enc_i(128, 15, 2, 8, 'h03), enc_i(2, 9, 2, 8, 'h03), enc_i(248, 9, 3, 8, 'h03),
            enc_i(244, 9, 3, 8, 'h03), enc_s(248, 15, 8, 3, 'h23), enc_i(8, 8, 3, 16, 'h03),
            enc_s(124, 9, 10, 2, 'h23), enc_s(-4, 9, 10, 2, 'h23)};
    while (ins.size() < 10000) ins.push_back(gen_inst());
    n16 = 0;
    foreach (ins[i]) if (model_c16(ins[i])) n16++;
    foreach (ins[i]) begin
      if ($urandom_range(0, 3) == 0) begin bus.out_ready_i = ($urandom_range(0, 3) != 0); cycle(); end
      bus.in_valid_i = 1'b1; bus.in_inst_i = ins[i]; accepted = 0;
      for (int n = 0; n < 100 && !accepted; n++) begin
        bus.out_ready_i = ($urandom_range(0, 3) != 0);
        cycle();
      end
      bus.in_valid_i = 1'b0;
      if (!accepted) begin
        total++; bad++;
        $display("FAIL rand_accept_timeout: index %0d accepted=0 required=1", i);
        break;
      end
    end
    flush_wait();
    p = 0;
    foreach (ins[i]) begin
      total++;
      if (p >= hw_q.size()) begin
        bad++; $display("FAIL rand_short: index %0d stream ended, want %h", i, ins[i]);
        break;
      end
      got16 = (hw_q[p][1:0] != 2'b11);
      if (got16) begin got = expand(hw_q[p]); p += 1; end
      else if (p + 1 < hw_q.size()) begin got = {hw_q[p+1], hw_q[p]}; p += 2; end
      else begin got = 32'hx; p += 1; end
      if (got !== ins[i] || got16 !== model_c16(ins[i])) begin
        bad++;
        if (bad < 20) $display("FAIL rand_roundtrip[%0d]: got %h c16=%b want %h c16=%b",
                               i, got, got16, ins[i], model_c16(ins[i]));
      end
    end
    total += 2;
    if (hw_q.size() - p != (n16 % 2) || (hw_q.size() - p == 1 && hw_q[p] !== 16'h0001)) begin
      bad++; $display("FAIL rand_tail: got %0d leftover halfwords want %0d (pad 0001)", hw_q.size() - p, n16 % 2);
    end
    if (bus.comp_cnt_o !== 32'(n16)) begin bad++; $display("FAIL rand_cnt: got %0d want %0d", bus.comp_cnt_o, n16); end
  endtask

  initial begin
    test_reset();
    test_addi_pair();
    test_lw_flush();
    test_mixed_lui();
    test_passthrough();
    test_backpressure();
    test_reset_mid();
    test_flush_block();
    test_cnt_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
